mod_mult_seq: RTL and testbench

- Bit-serial interleaved (Blakley) modular multiplier: computes R = (A * B) mod N, processing one bit of B per clock, MSB first.
- Core arithmetic stage of the RSA datapath. The exponentiation controller issues one square or multiply per start pulse and advances on the done pulse.
- Contains its own bit-iteration counter. It counts 0 to WIDTH-1 and holds at the terminal value.

---
 rtl/mod_mult_seq.sv | 137 +++++++++++++
 tb/tb_mod_mult_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_mult_seq.sv
// Bit-serial interleaved (Blakley) modular multiplier: result = (a * b) mod n,
// consuming one bit of b per clock, MSB first.
module mod_mult_seq #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic [WIDTH+1:0]   p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH+1:0]   a_ext, n_ext;
  logic [WIDTH+1:0]   t_sum, t_red1, t_red2;
  logic               operand_bad;

  // P < N keeps 2P + A below 3N, so two conditional subtractions suffice.
  always_comb begin
    a_ext       = {2'b00, a_q};
    n_ext       = {2'b00, n_q};
    t_sum       = (p_q << 1) + (b_q[WIDTH-1] ? a_ext : '0);
    t_red1      = (t_sum >= n_ext) ? (t_sum - n_ext) : t_sum;
    t_red2      = (t_red1 >= n_ext) ? (t_red1 - n_ext) : t_red1;
    operand_bad = (n_q == '0) || (a_q >= n_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An accepted request spends one IDLE cycle in req_q while the operands are checked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_q) state_d = operand_bad ? FIN : RUN;
      RUN:     if (cnt_q == CNT_LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == FIN);
    err    = err_q;
    result = result_q;
  end

  always_comb begin
    req_d    = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (req_q) begin
          err_d    = operand_bad;
          result_d = '0;
        end else if (start) begin
          req_d    = 1'b1;
          a_d      = a;
          b_d      = b;
          n_d      = n;
          p_d      = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
          result_d = '0;
        end
      end
      RUN: begin
        p_d = t_red2;
        b_d = b_q << 1;
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d = t_red2[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      req_q    <= req_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_mod_mult_seq.sv
// Directed and reference-model checks of mod_mult_seq at WIDTH=8 and WIDTH=64.
module tb_mod_mult_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, n8 = '0;
  logic        busy8, done8, err8;
  logic [7:0]  result8;

  logic        start64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0, n64 = '0;
  logic        busy64, done64, err64;
  logic [63:0] result64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_mult_seq #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8),
    .a(a8), .b(b8), .n(n8),
    .busy(busy8), .done(done8), .err(err8), .result(result8)
  );

  mod_mult_seq #(.WIDTH(64), .CNT_W(7)) dut64 (
    .clk(clk), .reset_n(reset_n), .start(start64),
    .a(a64), .b(b64), .n(n64),
    .busy(busy64), .done(done64), .err(err64), .result(result64)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] n;
    logic [7:0] exp_res;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Called #1 after a rising edge; the next edge is the accepting edge.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] nv,
                     input logic [7:0] er, input logic ee, input int elat, input string nm);
    int lat;
    lat = 0;
    a8 = av; b8 = bv; n8 = nv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); n8 = 8'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
    check({nm, ".latency"}, lat, elat);
    check({nm, ".result"}, result8, er);
    check({nm, ".err"}, err8, ee);
    $display("op8 %s a=%0d b=%0d n=%0d -> result=%0d err=%0d latency=%0d", nm, av, bv, nv, result8, err8, lat);
    @(posedge clk); #1;
    check({nm, ".done_drop"}, done8, 1'b0);
    check({nm, ".result_hold"}, result8, er);
  endtask

  vec_t vecs[8];

  initial begin
    logic [63:0]  ra, rb, rn;
    logic [127:0] prod;
    logic [63:0]  expv;
    int lat, bad_lat, bad_res, ndone;

    vecs[0] = '{8'd7,   8'd9,   8'd11,  8'd8,   1'b0, 9};
    vecs[1] = '{8'd250, 8'd255, 8'd251, 8'd247, 1'b0, 9};
    vecs[2] = '{8'd0,   8'd200, 8'd13,  8'd0,   1'b0, 9};
    vecs[3] = '{8'd0,   8'd255, 8'd1,   8'd0,   1'b0, 9};
    vecs[4] = '{8'd12,  8'd3,   8'd11,  8'd0,   1'b1, 1};
    vecs[5] = '{8'd3,   8'd4,   8'd11,  8'd1,   1'b0, 9};
    vecs[6] = '{8'd11,  8'd5,   8'd11,  8'd0,   1'b1, 1};
    vecs[7] = '{8'd5,   8'd0,   8'd0,   8'd0,   1'b1, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", busy8, 1'b0);
    check("reset.done", done8, 1'b0);
    check("reset.err", err8, 1'b0);
    check("reset.result", result8, 8'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Busy/done timeline for 7*9 mod 11 with start at edge 0.
    a8 = 8'd7; b8 = 8'd9; n8 = 8'd11; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k >= 1 && k <= 9) check($sformatf("timeline.busy%0d", k), busy8, 1'b1);
      else check("timeline.busy10", busy8, 1'b0);
      check($sformatf("timeline.done%0d", k), done8, (k == 9) ? 1'b1 : 1'b0);
    end
    check("timeline.result", result8, 8'd8);
    $display("op8 timeline a=7 b=9 n=11 -> result=%0d err=%0d", result8, err8);

    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].exp_res, vecs[i].exp_err,
          vecs[i].exp_lat, $sformatf("vec%0d", i));
    end

    // start held high with changing operands: only the first request counts.
    a8 = 8'd6; b8 = 8'd10; n8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
    check("hold.latency", lat, 9);
    check("hold.result", result8, 8'd8);
    $display("op8 hold a=6 b=10 n=13 -> result=%0d latency=%0d", result8, lat);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(posedge clk); #1;
    check("hold.idle_after_fin", busy8, 1'b0);
    op8(8'd2, 8'd3, 8'd13, 8'd6, 1'b0, 9, "after_hold");

    // Asynchronous reset in the middle of a run.
    a8 = 8'd6; b8 = 8'd5; n8 = 8'd7; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("abort.busy_before", busy8, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort.busy", busy8, 1'b0);
    check("abort.done", done8, 1'b0);
    check("abort.err", err8, 1'b0);
    check("abort.result", result8, 8'd0);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    check("abort.no_done", ndone, 0);
    op8(8'd5, 8'd5, 8'd7, 8'd4, 1'b0, 9, "after_abort");

    // WIDTH=64 against a 128-bit reference product.
    bad_lat = 0;
    bad_res = 0;
    for (int t = 0; t < 200; t++) begin
      rn = {$urandom, $urandom};
      if (t == 0) rn = 64'hFFFF_FFFF_FFFF_FFFF;
      if (rn == 64'd0) rn = 64'd1;
      ra = {$urandom, $urandom} % rn;
      rb = (t == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      if (t == 0) ra = rn - 64'd1;
      prod = {64'd0, ra} * {64'd0, rb};
      expv = 64'(prod % {64'd0, rn});
      a64 = ra; b64 = rb; n64 = rn; start64 = 1'b1;
      @(posedge clk); #1;
      start64 = 1'b0;
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
        @(posedge clk); #1;
        if (done64) begin
          lat = k;
          break;
        end
      end
      if (lat != 65) bad_lat++;
      if (result64 !== expv || err64 !== 1'b0) bad_res++;
      $display("op64 %0d a=%0h b=%0h n=%0h -> result=%0h expected=%0h latency=%0d",
               t, ra, rb, rn, result64, expv, lat);
      @(posedge clk); #1;
    end
    check("w64.latency_errors", bad_lat, 0);
    check("w64.result_errors", bad_res, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
